// File: rtl/ltsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ltsm_pkg
//  Purpose  : Shared definitions for the MBTRAIN step handshake engines:
//             sideband message codes, FSM state encodings and the default
//             counter width.
//  Revision : 1.0 - initial release
// ============================================================================
package ltsm_pkg;

    // Sideband message codes for the simple request/response steps
    localparam logic [3:0] C_SELFCAL_REQ    = 4'h1;
    localparam logic [3:0] C_SELFCAL_RESP   = 4'h2;
    localparam logic [3:0] C_REPAIRCLK_REQ  = 4'h3;
    localparam logic [3:0] C_REPAIRCLK_RESP = 4'h4;

    // Default counter width; must cover the larger of the step timeout and
    // the response wait
    localparam int C_DEFAULT_CNT_W = 11;

    // Local request path: send request, wait for the partner's response
    typedef enum logic [2:0] {
        TX_IDLE        = 3'd0,
        TX_SEND_REQ    = 3'd1,
        TX_WAIT_ACCEPT = 3'd2,
        TX_WAIT_RESP   = 3'd3,
        TX_DONE        = 3'd4,
        TX_FAIL        = 3'd5
    } tx_state_e;

    // Local response path: wait for the partner's request, send response
    typedef enum logic [2:0] {
        RX_IDLE        = 3'd0,
        RX_WAIT_REQ    = 3'd1,
        RX_SEND_RESP   = 3'd2,
        RX_WAIT_ACCEPT = 3'd3,
        RX_DONE        = 3'd4
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/sb_busy_fall_detect.sv
`default_nettype none
// ============================================================================
//  Module   : sb_busy_fall_detect
//  Purpose  : Registered falling-edge detector on the sideband transmitter
//             busy flag. A 1->0 transition of i_busy produces a one-cycle
//             pulse on o_busy_fall, one cycle after i_busy is first seen low.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             i_busy          - sideband transmitter busy
//             o_busy_q        - i_busy delayed by one cycle
//             o_busy_fall     - registered busy-fall pulse
//  Revision : 1.0 - initial release
// ============================================================================
module sb_busy_fall_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_busy,
    output logic o_busy_q,
    output logic o_busy_fall
);

    logic r_busy_q;
    logic r_busy_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy_q    <= 1'b0;
            r_busy_fall <= 1'b0;
        end else begin
            r_busy_q    <= i_busy;
            r_busy_fall <= r_busy_q & ~i_busy;
        end
    end

    assign o_busy_q    = r_busy_q;
    assign o_busy_fall = r_busy_fall;

endmodule
`default_nettype wire

// File: rtl/mbtrain_step_handshake.sv
`default_nettype none
// ============================================================================
//  Module   : mbtrain_step_handshake
//  Purpose  : Generic MBTRAIN sub-state request/response handshake engine.
//             The TX path sends REQ_CODE and waits for RESP_CODE (with
//             retries); the RX path waits for REQ_CODE and answers with
//             RESP_CODE. Both share one sideband message port through an
//             arbiter (RX has priority) with flow control on i_busy.
//  Ports    : clk, rst                    - clock, sync active-high reset
//             i_en                        - step enable (level)
//             i_decoded_sideband_message  - incoming message code
//             i_sideband_valid            - strobe for incoming message
//             i_busy                      - sideband transmitter busy
//             o_sideband_message          - outgoing message code
//             o_valid                     - outgoing message valid
//             o_test_ack                  - step complete
//             o_timeout                   - step failed
//  Revision : 1.0 - initial release
// ============================================================================
module mbtrain_step_handshake
    import ltsm_pkg::*;
#(
    parameter int               MSG_W         = 4,
    parameter logic [MSG_W-1:0] REQ_CODE      = MSG_W'(C_SELFCAL_REQ),
    parameter logic [MSG_W-1:0] RESP_CODE     = MSG_W'(C_SELFCAL_RESP),
    parameter int               RESP_WAIT_CYC = 32,
    parameter int               MAX_RETRY     = 2,
    parameter int               TIMEOUT_CYC   = 1024,
    parameter int               CNT_W         = C_DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [MSG_W-1:0] i_decoded_sideband_message,
    input  logic             i_sideband_valid,
    input  logic             i_busy,
    output logic [MSG_W-1:0] o_sideband_message,
    output logic             o_valid,
    output logic             o_test_ack,
    output logic             o_timeout
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]   C_RESP_WAIT_LAST = CNT_W'(RESP_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0]   C_TIMEOUT        = CNT_W'(TIMEOUT_CYC);
    localparam logic [RETRY_W-1:0] C_MAX_RETRY      = RETRY_W'(MAX_RETRY);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    tx_state_e          r_tx_state;
    rx_state_e          r_rx_state;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]   r_step_cnt;
    logic [RETRY_W-1:0] r_retry_cnt;
    logic [MSG_W-1:0]   r_msg;
    logic               r_valid;
    logic               r_test_ack;
    logic               r_timeout;

    // ------------------------------------------------------------------
    // Busy falling-edge detector
    // ------------------------------------------------------------------
    logic w_busy_q;
    logic w_busy_fall;

    sb_busy_fall_detect u_busy_fall (
        .clk         (clk),
        .rst         (rst),
        .i_busy      (i_busy),
        .o_busy_q    (w_busy_q),
        .o_busy_fall (w_busy_fall)
    );

    // ------------------------------------------------------------------
    // Incoming message decode; codes other than REQ/RESP are ignored
    // ------------------------------------------------------------------
    logic w_msg_req;
    logic w_msg_resp;

    assign w_msg_req  = i_sideband_valid && (i_decoded_sideband_message == REQ_CODE);
    assign w_msg_resp = i_sideband_valid && (i_decoded_sideband_message == RESP_CODE);

    // ------------------------------------------------------------------
    // Arbiter
    // The port is free when nothing is outstanding and busy is low. Busy
    // must also have been low in the previous cycle: otherwise the fall
    // pulse of someone else's transfer would land on a freshly granted
    // message and be mistaken for its acceptance.
    // ------------------------------------------------------------------
    logic w_arb_free;
    logic w_rx_pending;
    logic w_tx_pending;
    logic w_grant_rx;
    logic w_grant_tx;
    logic w_accept;

    assign w_arb_free   = !i_busy && !w_busy_q && !r_valid;
    assign w_rx_pending = (r_rx_state == RX_SEND_RESP);
    assign w_tx_pending = (r_tx_state == TX_SEND_REQ);
    assign w_grant_rx   = w_arb_free && w_rx_pending;
    assign w_grant_tx   = w_arb_free && w_tx_pending && !w_rx_pending;
    // Only one message can be outstanding, so the pulse belongs to it
    assign w_accept     = r_valid && w_busy_fall;

    // ------------------------------------------------------------------
    // Completion
    // ------------------------------------------------------------------
    logic w_wait_expired;
    logic w_step_expired;
    logic w_timeout_next;
    logic w_both_done;

    assign w_wait_expired = (r_wait_cnt == C_RESP_WAIT_LAST);
    assign w_step_expired = (r_step_cnt >= C_TIMEOUT);
    assign w_timeout_next = r_timeout || (r_tx_state == TX_FAIL) ||
                            (w_step_expired && !r_test_ack);
    assign w_both_done    = (r_tx_state == TX_DONE) && (r_rx_state == RX_DONE);

    // ------------------------------------------------------------------
    // FSMs, message port and counters
    // Dropping i_en behaves like reset for everything except the busy
    // detector, which keeps tracking the physical busy line.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_tx_state  <= TX_IDLE;
            r_rx_state  <= RX_IDLE;
            r_wait_cnt  <= '0;
            r_step_cnt  <= '0;
            r_retry_cnt <= '0;
            r_msg       <= '0;
            r_valid     <= 1'b0;
            r_test_ack  <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            // Outgoing message: held stable from grant until accepted
            if (w_grant_rx) begin
                r_msg   <= RESP_CODE;
                r_valid <= 1'b1;
            end else if (w_grant_tx) begin
                r_msg   <= REQ_CODE;
                r_valid <= 1'b1;
            end else if (w_accept) begin
                r_msg   <= '0;
                r_valid <= 1'b0;
            end

            // TX path
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx_state <= TX_SEND_REQ;
                end
                TX_SEND_REQ: begin
                    if (w_grant_tx) begin
                        r_tx_state <= TX_WAIT_ACCEPT;
                    end
                end
                TX_WAIT_ACCEPT: begin
                    if (w_accept) begin
                        r_tx_state <= TX_WAIT_RESP;
                        r_wait_cnt <= '0;
                    end
                end
                TX_WAIT_RESP: begin
                    if (w_msg_resp) begin
                        r_tx_state <= TX_DONE;
                    end else if (w_wait_expired) begin
                        r_wait_cnt <= '0;
                        if (r_retry_cnt < C_MAX_RETRY) begin
                            r_retry_cnt <= r_retry_cnt + RETRY_W'(1);
                            r_tx_state  <= TX_SEND_REQ;
                        end else begin
                            r_tx_state <= TX_FAIL;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                TX_DONE, TX_FAIL: begin
                    r_tx_state <= r_tx_state;
                end
                default: begin
                    r_tx_state <= TX_IDLE;
                end
            endcase

            // RX path
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_state <= RX_WAIT_REQ;
                end
                RX_WAIT_REQ: begin
                    if (w_msg_req) begin
                        r_rx_state <= RX_SEND_RESP;
                    end
                end
                RX_SEND_RESP: begin
                    if (w_grant_rx) begin
                        r_rx_state <= RX_WAIT_ACCEPT;
                    end
                end
                RX_WAIT_ACCEPT: begin
                    if (w_accept) begin
                        r_rx_state <= RX_DONE;
                    end
                end
                RX_DONE: begin
                    // Partner retried: its copy of our response was lost
                    if (w_msg_req) begin
                        r_rx_state <= RX_SEND_RESP;
                    end
                end
                default: begin
                    r_rx_state <= RX_IDLE;
                end
            endcase

            // Step counter: frozen after ack, saturates at the timeout
            if (!r_test_ack && !w_timeout_next && (r_step_cnt < C_TIMEOUT)) begin
                r_step_cnt <= r_step_cnt + CNT_W'(1);
            end

            // Timeout takes precedence over ack in the same cycle
            r_timeout  <= w_timeout_next;
            r_test_ack <= !w_timeout_next && (r_test_ack || w_both_done);
        end
    end

    assign o_sideband_message = r_msg;
    assign o_valid            = r_valid;
    assign o_test_ack         = r_test_ack;
    assign o_timeout          = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mbtrain_step_handshake.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mbtrain_step_handshake
//  Purpose  : Directed self-checking bench for mbtrain_step_handshake with a
//             scoreboard queue of expected outgoing sideband messages.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mbtrain_step_handshake;

    localparam logic [3:0] REQ  = 4'h5;
    localparam logic [3:0] RESP = 4'h6;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_en;
    logic [3:0] i_decoded_sideband_message;
    logic       i_sideband_valid;
    logic       i_busy;
    logic [3:0] o_sideband_message;
    logic       o_valid;
    logic       o_test_ack;
    logic       o_timeout;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_q[$];
    logic [3:0] cur_exp   = 4'h0;
    logic       prev_valid = 1'b0;
    int         req_sends  = 0;

    mbtrain_step_handshake #(
        .MSG_W         (4),
        .REQ_CODE      (REQ),
        .RESP_CODE     (RESP),
        .RESP_WAIT_CYC (16),
        .MAX_RETRY     (2),
        .TIMEOUT_CYC   (200),
        .CNT_W         (11)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .i_en                       (i_en),
        .i_decoded_sideband_message (i_decoded_sideband_message),
        .i_sideband_valid           (i_sideband_valid),
        .i_busy                     (i_busy),
        .o_sideband_message         (o_sideband_message),
        .o_valid                    (o_valid),
        .o_test_ack                 (o_test_ack),
        .o_timeout                  (o_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each new outgoing message must match the head of the
    // queue, and stay equal to it for as long as o_valid is held.
    always @(negedge clk) begin
        if (o_valid === 1'b1 && prev_valid !== 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected_send: observed=%0h expected=none", o_sideband_message);
            end
            if (exp_q.size() != 0) begin
                cur_exp = exp_q.pop_front();
                chk("sb_msg", {28'd0, o_sideband_message}, {28'd0, cur_exp});
            end
            if (o_sideband_message === REQ) req_sends++;
        end else if (o_valid === 1'b1) begin
            chk("sb_msg_stable", {28'd0, o_sideband_message}, {28'd0, cur_exp});
        end
        prev_valid = o_valid;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_msg(input logic [3:0] code);
        i_decoded_sideband_message = code;
        i_sideband_valid           = 1'b1;
        tick();
        i_sideband_valid           = 1'b0;
        i_decoded_sideband_message = 4'h0;
    endtask

    // Bounded wait for o_valid; n returns the number of cycles waited
    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (o_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, o_valid}, 32'd1);
    endtask

    // Partner accepts the outstanding message with a 3-cycle busy pulse.
    // The fall pulse is registered one cycle after busy is seen low, and
    // o_valid drops one cycle after that.
    task automatic accept(input string tag);
        i_busy = 1'b1;
        repeat (3) tick();
        i_busy = 1'b0;
        tick();
        chk({tag, "_held_at_pulse"}, {31'd0, o_valid}, 32'd1);
        tick();
        chk({tag, "_drop_after_pulse"}, {31'd0, o_valid}, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_msg"},     {28'd0, o_sideband_message}, 32'd0);
        chk({tag, "_valid"},   {31'd0, o_valid},            32'd0);
        chk({tag, "_ack"},     {31'd0, o_test_ack},         32'd0);
        chk({tag, "_timeout"}, {31'd0, o_timeout},          32'd0);
    endtask

    // Partner's response completes TX; ack follows one cycle later
    task automatic finish_with_resp(input string tag);
        send_msg(RESP);
        chk({tag, "_ack_not_yet"}, {31'd0, o_test_ack}, 32'd0);
        tick();
        chk({tag, "_ack"},     {31'd0, o_test_ack}, 32'd1);
        chk({tag, "_no_tout"}, {31'd0, o_timeout},  32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;

        rst = 1'b1;
        i_en = 1'b0;
        i_decoded_sideband_message = 4'h0;
        i_sideband_valid = 1'b0;
        i_busy = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // ---------------- Normal step ----------------
        exp_q.push_back(REQ);
        i_en = 1'b1;
        wait_valid("normal_tx_send", n);
        // Partner request arrives while our request is outstanding
        exp_q.push_back(RESP);
        send_msg(REQ);
        accept("normal_tx");
        wait_valid("normal_rx_send", n);
        accept("normal_rx");
        finish_with_resp("normal");
        repeat (3) tick();
        chk("normal_ack_held", {31'd0, o_test_ack}, 32'd1);
        i_en = 1'b0;
        tick();
        chk_all_zero("normal_disable");

        // ------- Simultaneous pending + busy hold -------
        i_busy = 1'b1;
        exp_q.push_back(RESP);
        exp_q.push_back(REQ);
        i_en = 1'b1;
        tick();                     // TX request now pending, blocked by busy
        send_msg(REQ);              // RX request pending in the same window
        for (int i = 0; i < 9; i++) begin
            chk("busy_hold_no_valid", {31'd0, o_valid}, 32'd0);
            tick();
        end
        i_busy = 1'b0;
        wait_valid("simul_first_send", n);
        accept("simul_rx");
        wait_valid("simul_second_send", n);
        accept("simul_tx");
        finish_with_resp("simul");
        i_en = 1'b0;
        tick();

        // ---------------- Retry ----------------
        base = req_sends;
        exp_q.push_back(REQ);
        i_en = 1'b1;
        wait_valid("retry_send0", n);
        accept("retry0");
        for (int k = 1; k < 3; k++) begin
            exp_q.push_back(REQ);
            // 16 cycles in the response wait plus one cycle of arbitration
            wait_valid("retry_resend", n);
            chk("retry_gap", n, 32'd17);
            accept("retry_k");
        end
        exp_q.push_back(RESP);
        send_msg(REQ);
        wait_valid("retry_rx_send", n);
        accept("retry_rx");
        finish_with_resp("retry");
        chk("retry_req_count", req_sends - base, 32'd3);
        i_en = 1'b0;
        tick();

        // ---------------- Exhausted retry ----------------
        base = req_sends;
        i_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(REQ);
            wait_valid("exh_send", n);
            accept("exh");
        end
        n = 0;
        while (o_timeout !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk("exh_timeout", {31'd0, o_timeout}, 32'd1);
        chk("exh_timeout_latency", n, 32'd17);
        chk("exh_no_ack", {31'd0, o_test_ack}, 32'd0);
        repeat (5) tick();
        chk("exh_timeout_held", {31'd0, o_timeout}, 32'd1);
        chk("exh_req_count", req_sends - base, 32'd3);
        i_en = 1'b0;
        tick();
        chk_all_zero("exh_disable");

        // ------------- Busy stuck: step timeout -------------
        i_busy = 1'b1;
        i_en = 1'b1;
        repeat (200) tick();
        chk("stuck_no_timeout_yet", {31'd0, o_timeout}, 32'd0);
        chk("stuck_no_valid", {31'd0, o_valid}, 32'd0);
        tick();
        chk("stuck_timeout", {31'd0, o_timeout}, 32'd1);
        chk("stuck_no_ack", {31'd0, o_test_ack}, 32'd0);
        i_en = 1'b0;
        i_busy = 1'b0;
        tick();
        chk_all_zero("stuck_disable");
        repeat (2) tick();

        // ---------------- Abort and reset ----------------
        exp_q.push_back(REQ);
        i_en = 1'b1;
        wait_valid("abort_send", n);
        i_busy = 1'b1;
        tick();
        i_en = 1'b0;
        tick();
        chk_all_zero("abort");
        i_busy = 1'b0;
        repeat (2) tick();
        exp_q.push_back(REQ);
        i_en = 1'b1;
        wait_valid("abort_restart_send", n);
        accept("abort_restart");
        rst = 1'b1;
        tick();
        chk_all_zero("midstep_reset");
        exp_q.push_back(REQ);
        rst = 1'b0;
        wait_valid("reset_restart_send", n);
        accept("reset_restart");
        i_en = 1'b0;
        tick();
        chk_all_zero("final_disable");
        chk("sb_queue_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
